// File: rtl/dbg_bridge.sv
// dbg_bridge: serial command stream to single read/write cycles on the system bus
module dbg_bridge #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] addr,
  output logic [7:0]  dbw,
  input  logic [7:0]  dbr,
  output logic        we,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, AHI, ALO, DATA, REQ, ACC, RD, RESP} state_t;
  localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);
  state_t state, state_n;
  logic is_write;
  logic [1:0] cnt;
  logic acc;
  logic known;
  assign acc = rx_valid & rx_ready;
  assign known = (rx_data == 8'h57) | (rx_data == 8'h52);
  assign rx_ready = state inside {IDLE, AHI, ALO, DATA};
  assign bus_req = state inside {REQ, ACC, RD};
  assign tx_valid = state == RESP;
  assign we = (state == ACC) & is_write & bus_gnt;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = acc ? (known ? AHI : RESP) : IDLE;
      AHI:  state_n = acc ? ALO : AHI;
      ALO:  state_n = acc ? (is_write ? DATA : REQ) : ALO;
      DATA: state_n = acc ? REQ : DATA;
      REQ:  state_n = bus_gnt ? ACC : REQ;
      ACC:  state_n = !bus_gnt ? REQ : is_write ? RESP : RD;
      RD:   state_n = !bus_gnt ? REQ : (cnt == LAST) ? RESP : RD;
      RESP: state_n = tx_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      is_write <= 1'b0;
      addr     <= '0;
      dbw      <= '0;
      tx_data  <= '0;
      cnt      <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && acc) is_write <= rx_data == 8'h57;
      if (state == IDLE && acc && !known) tx_data <= 8'h3F;
      if (state == AHI && acc) addr[15:8] <= rx_data;
      if (state == ALO && acc) addr[7:0] <= rx_data;
      if (state == DATA && acc) dbw <= rx_data;
      if (we) tx_data <= 8'h2E;
      // a lost grant restarts the latency count from the next ACC
      cnt <= (state == RD) ? cnt + 2'd1 : 2'd0;
      if (state == RD && bus_gnt && cnt == LAST) tx_data <= dbr;
    end
  end
endmodule

// File: tb/tb_dbg_bridge.sv
// tb_dbg_bridge: directed command vectors checked against a transaction-level bridge model
module tb_dbg_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic rx_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b1;
  logic bus_req;
  logic bus_gnt;
  logic [15:0] addr;
  logic [7:0] dbw;
  logic [7:0] dbr = '0;
  logic we;
  logic busy;

  dbg_bridge #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .addr(addr), .dbw(dbw), .dbr(dbr), .we(we), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] mem [0:65535];
  logic man_mode = 1'b0;
  logic gnt_man = 1'b0;
  logic gnt_auto = 1'b0;
  int gnt_delay = 0;
  int gnt_cnt = 0;
  assign bus_gnt = man_mode ? gnt_man : gnt_auto;

  // bus slave: registered read one cycle after address, arbiter grants after gnt_delay cycles
  always @(posedge clk) begin
    dbr <= mem[addr];
    if (!bus_req) begin
      gnt_cnt <= 0;
      gnt_auto <= 1'b0;
    end else if (gnt_cnt >= gnt_delay) gnt_auto <= 1'b1;
    else gnt_cnt <= gnt_cnt + 1;
  end

  logic [7:0] exp_resp [$];
  logic [23:0] exp_wr [$];
  logic [15:0] exp_addr = '0;
  logic exp_addr_v = 1'b0;
  int req_cycles = 0, we_cycles = 0, resp_cnt = 0, hold_cycles = 0;
  logic [7:0] last_resp = '0, last_we_data = '0, prev_data = '0;
  logic [15:0] last_we_addr = '0;
  logic prev_hold = 1'b0;
  logic [23:0] w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_tx_valid", 32'(tx_valid), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_we", 32'(we), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_dbw", 32'(dbw), 0);
      chk("rst_busy", 32'(busy), 0);
      prev_hold = 1'b0;
    end else begin
      chk("rx_ready_rule", 32'(rx_ready), 32'(!(bus_req || tx_valid)));
      if (bus_req || tx_valid) chk("busy_rule", 32'(busy), 1);
      if (prev_hold) begin
        hold_cycles++;
        chk("tx_hold_valid", 32'(tx_valid), 1);
        chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (bus_req && bus_gnt && exp_addr_v) chk("bus_addr", 32'(addr), 32'(exp_addr));
      if (bus_req) req_cycles++;
      if (we) begin
        we_cycles++;
        chk("we_owned", 32'(bus_gnt && bus_req), 1);
        if (exp_wr.size() == 0) chk("we_expected", 32'(exp_wr.size()), 1);
        else begin
          w = exp_wr.pop_front();
          chk("we_addr", 32'(addr), 32'(w[23:8]));
          chk("we_data", 32'(dbw), 32'(w[7:0]));
          last_we_addr = addr;
          last_we_data = dbw;
        end
      end
      if (tx_valid && tx_ready) begin
        resp_cnt++;
        last_resp = tx_data;
        if (exp_resp.size() == 0) chk("resp_expected", 32'(exp_resp.size()), 1);
        else chk("resp_data", 32'(tx_data), 32'(exp_resp.pop_front()));
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  task automatic expect_cmd(input logic [7:0] op, input logic [15:0] a, input logic [7:0] d);
    if (op == 8'h57) begin
      exp_resp.push_back(8'h2E);
      exp_wr.push_back({a, d});
      exp_addr = a;
      exp_addr_v = 1'b1;
    end else if (op == 8'h52) begin
      exp_resp.push_back(mem[a]);
      exp_addr = a;
      exp_addr_v = 1'b1;
    end else exp_resp.push_back(8'h3F);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic a;
    rx_data = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      a = rx_ready;
      @(posedge clk);
      n++;
    end while (!a && n < 200);
    #1 rx_valid = 1'b0;
    chk("rx_accept", 32'(a), 1);
  endtask

  task automatic send_bytes(input logic [7:0] op, input logic [15:0] a, input logic [7:0] d);
    send_byte(op);
    if (op == 8'h57 || op == 8'h52) begin
      send_byte(a[15:8]);
      send_byte(a[7:0]);
    end
    if (op == 8'h57) send_byte(d);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, input logic [7:0] d);
    expect_cmd(op, a, d);
    send_bytes(op, a, d);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((busy || exp_resp.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(nm, 32'(n < 300), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, q0, w0, h0, n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7);
    mem[16'hFE20] = 8'h3C;
    mem[16'hFFFC] = 8'hA5;
    mem[16'hFE00] = 8'h11;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_rx_ready", 32'(rx_ready), 1);
    // reset in the middle of a command
    send_byte(8'h52);
    chk("busy_in_ahi", 32'(busy), 1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    r0 = resp_cnt;
    send_cmd(8'h52, 16'hFE20, 8'h00);
    wait_done("t1_done");
    chk("t1_one_resp", 32'(resp_cnt - r0), 1);
    chk("t1_data", 32'(last_resp), 32'h3C);
    // write with delayed grant
    gnt_delay = 4;
    q0 = req_cycles;
    w0 = we_cycles;
    send_cmd(8'h57, 16'hFE01, 8'h5A);
    wait_done("t2_done");
    chk("t2_one_we", 32'(we_cycles - w0), 1);
    chk("t2_req_long", 32'(req_cycles - q0 >= 5), 1);
    chk("t2_resp", 32'(last_resp), 32'h2E);
    chk("t2_we_addr", 32'(last_we_addr), 32'hFE01);
    chk("t2_we_data", 32'(last_we_data), 32'h5A);
    chk("t2_addr_hold", 32'(addr), 32'hFE01);
    chk("t2_dbw_hold", 32'(dbw), 32'h5A);
    gnt_delay = 0;
    // invalid opcode, then a normal read
    q0 = req_cycles;
    send_cmd(8'h41, 16'h0000, 8'h00);
    wait_done("t3_done_inv");
    chk("t3_no_req", 32'(req_cycles - q0), 0);
    chk("t3_inv_resp", 32'(last_resp), 32'h3F);
    w0 = we_cycles;
    send_cmd(8'h52, 16'hFFFC, 8'h00);
    wait_done("t3_done_rd");
    chk("t3_rd_resp", 32'(last_resp), 32'hA5);
    chk("t3_no_we", 32'(we_cycles - w0), 0);
    // grant lost during the read data cycle
    man_mode = 1'b1;
    gnt_man = 1'b0;
    r0 = resp_cnt;
    expect_cmd(8'h52, 16'hFE00, 8'h00);
    void'(exp_resp.pop_back());
    exp_resp.push_back(8'h77);
    send_bytes(8'h52, 16'hFE00, 8'h00);
    n = 0;
    while (!bus_req && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 gnt_man = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 gnt_man = 1'b0;
    mem[16'hFE00] = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_req_held", 32'(bus_req), 1);
    chk("t4_no_early_resp", 32'(tx_valid), 0);
    gnt_man = 1'b1;
    wait_done("t4_done");
    chk("t4_one_resp", 32'(resp_cnt - r0), 1);
    chk("t4_second_sample", 32'(last_resp), 32'h77);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_gnt_ignored_busy", 32'(busy), 0);
    chk("t4_gnt_ignored_req", 32'(bus_req), 0);
    gnt_man = 1'b0;
    man_mode = 1'b0;
    // response backpressure with the next command queued behind it
    tx_ready = 1'b0;
    r0 = resp_cnt;
    h0 = hold_cycles;
    send_cmd(8'h52, 16'hFFFC, 8'h00);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("t5_tx_valid", 32'(tx_valid), 1);
    fork
      send_cmd(8'h57, 16'h1234, 8'hC3);
      begin
        repeat (10) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    join
    wait_done("t5_done");
    chk("t5_two_resp", 32'(resp_cnt - r0), 2);
    chk("t5_held", 32'(hold_cycles - h0 >= 9), 1);
    chk("t5_last_resp", 32'(last_resp), 32'h2E);
    chk("t5_we_addr", 32'(last_we_addr), 32'h1234);
    chk("t5_queues_empty", 32'(exp_wr.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
